// File: rtl/dff_pkg.sv
// Shared encodings for the shift register: the operation modes and the burst FSM states.
package dff_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROTL = 3'd4,
    MODE_ROTR = 3'd5
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/dff_shift_reg_if.sv
// Control, data and status bundle of the shift register; clock and reset stay outside.
interface dff_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             sync_clr;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             sout_msb;
  logic             sout_lsb;
  logic             busy;
  logic             done;

  modport master (
    output sync_clr, en, mode, d, sin, start, amount,
    input  q, sout_msb, sout_lsb, busy, done
  );

  modport slave (
    input  sync_clr, en, mode, d, sin, start, amount,
    output q, sout_msb, sout_lsb, busy, done
  );
endinterface

// File: rtl/dff_shift_unit.sv
// Combinational next-value datapath, used by both single-cycle operations and burst steps.
module dff_shift_unit
  import dff_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    case (mode)
      MODE_LOAD: next_q = d;
      MODE_SHL:  next_q = {q[WIDTH-2:0], sin};
      MODE_SHR:  next_q = {sin, q[WIDTH-1:1]};
      MODE_ROTL: next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: next_q = {q[0], q[WIDTH-1:1]};
      default:   next_q = q;
    endcase
  end

endmodule

// File: rtl/dff_shift_reg.sv
// Shift register with single-cycle operations and a counted burst mode.
// state    | meaning
// ST_IDLE  | single-cycle ops on en; start latches mode/amount
// ST_BURST | latched op applied once per cycle until the count expires
module dff_shift_reg
  import dff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic           clk,
  input logic           reset,
  dff_shift_reg_if.slave bus
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       mode_lat, mode_lat_nxt;
  logic [WIDTH-1:0] q_r, q_nxt, shift_q;
  logic             done_r, done_nxt;
  logic [2:0]       op_mode;

  // During a burst the live mode input is ignored in favour of the latched one.
  assign op_mode = (state == ST_BURST) ? mode_lat : bus.mode;

  dff_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .mode   (op_mode),
    .q      (q_r),
    .d      (bus.d),
    .sin    (bus.sin),
    .next_q (shift_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mode_lat <= 3'd0;
      q_r      <= '0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mode_lat <= mode_lat_nxt;
      q_r      <= q_nxt;
      done_r   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    mode_lat_nxt = mode_lat;
    q_nxt        = q_r;
    done_nxt     = 1'b0;
    if (bus.sync_clr) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      q_nxt     = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mode_lat_nxt = bus.mode;
            if (bus.amount == '0) begin
              done_nxt = 1'b1;
            end else begin
              cnt_nxt   = bus.amount;
              state_nxt = ST_BURST;
            end
          end else if (bus.en) begin
            q_nxt = shift_q;
          end
        end
        ST_BURST: begin
          q_nxt   = shift_q;
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.q        = q_r;
  assign bus.sout_msb = q_r[WIDTH-1];
  assign bus.sout_lsb = q_r[0];
  assign bus.busy     = (state == ST_BURST);
  assign bus.done     = done_r;

endmodule

// File: tb/tb_dff_shift_reg.sv
// Directed self-checking bench for dff_shift_reg at WIDTH=8.
module tb_dff_shift_reg;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_SHR  = 3'd3;
  localparam logic [2:0] M_ROTL = 3'd4;
  localparam logic [2:0] M_ROTR = 3'd5;
  localparam logic [2:0] M_RSV  = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dff_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

  dff_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.sync_clr = 1'b0;
    bus.en       = 1'b0;
    bus.mode     = M_HOLD;
    bus.d        = 8'h00;
    bus.sin      = 1'b0;
    bus.start    = 1'b0;
    bus.amount   = 4'd0;
  endtask

  task automatic load(input logic [7:0] val);
    bus.en = 1'b1; bus.mode = M_LOAD; bus.d = val;
    step();
    bus.en = 1'b0; bus.mode = M_HOLD;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #13;
    n_cmp++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL reset_q got %h want 00", bus.q); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
    reset = 1'b0;
    step();
    bus.en = 1'b1; bus.mode = M_LOAD; bus.d = 8'hA5;
    step();
    bus.en = 1'b0;
    n_cmp++; if (bus.q !== 8'hA5) begin n_err++; $display("FAIL load_a5 got %h want a5", bus.q); end
  endtask

  task automatic test_burst_rotl();
    int busy_cnt = 0, done_cnt = 0, overlap = 0;
    bus.start = 1'b1; bus.mode = M_ROTL; bus.amount = 4'd3;
    step();
    bus.start = 1'b0; bus.mode = M_SHR; bus.amount = 4'd7; bus.d = 8'h00;
    n_cmp++; if (bus.q !== 8'hA5) begin n_err++; $display("FAIL rotl_start_q got %h want a5", bus.q); end
    for (int i = 0; i < 8; i++) begin
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      if (bus.done && bus.busy) overlap++;
      step();
    end
    n_cmp++; if (busy_cnt !== 3) begin n_err++; $display("FAIL rotl_busy_cycles got %0d want 3", busy_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rotl_done_pulses got %0d want 1", done_cnt); end
    n_cmp++; if (overlap !== 0) begin n_err++; $display("FAIL rotl_done_with_busy got %0d want 0", overlap); end
    n_cmp++; if (bus.q !== 8'h2D) begin n_err++; $display("FAIL rotl_q got %h want 2d", bus.q); end
    bus.mode = M_HOLD;
  endtask

  task automatic test_burst_shr();
    int done_cnt = 0;
    load(8'h81);
    bus.start = 1'b1; bus.mode = M_SHR; bus.sin = 1'b1; bus.amount = 4'd4;
    step();
    bus.start = 1'b0; bus.mode = M_HOLD;
    for (int i = 0; i < 6; i++) begin
      done_cnt += int'(bus.done);
      step();
    end
    bus.sin = 1'b0;
    n_cmp++; if (bus.q !== 8'hF8) begin n_err++; $display("FAIL shr_q got %h want f8", bus.q); end
    n_cmp++; if (bus.sout_lsb !== 1'b0) begin n_err++; $display("FAIL shr_sout_lsb got %b want 0", bus.sout_lsb); end
    n_cmp++; if (bus.sout_msb !== 1'b1) begin n_err++; $display("FAIL shr_sout_msb got %b want 1", bus.sout_msb); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL shr_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_single_ops();
    bus.en = 1'b1; bus.mode = M_SHL; bus.sin = 1'b0;
    step();
    n_cmp++; if (bus.q !== 8'hF0) begin n_err++; $display("FAIL shl_q got %h want f0", bus.q); end
    bus.mode = M_ROTR;
    step();
    n_cmp++; if (bus.q !== 8'h78) begin n_err++; $display("FAIL rotr_q got %h want 78", bus.q); end
    bus.mode = M_RSV;
    step();
    n_cmp++; if (bus.q !== 8'h78) begin n_err++; $display("FAIL reserved_q got %h want 78", bus.q); end
    bus.en = 1'b0; bus.mode = M_LOAD; bus.d = 8'hFF;
    step();
    n_cmp++; if (bus.q !== 8'h78) begin n_err++; $display("FAIL en0_hold_q got %h want 78", bus.q); end
    bus.en = 1'b1; bus.mode = M_ROTL;
    step();
    bus.en = 1'b0; bus.mode = M_HOLD;
    n_cmp++; if (bus.q !== 8'hF0) begin n_err++; $display("FAIL rotl1_q got %h want f0", bus.q); end
  endtask

  task automatic test_zero_amount();
    int busy_cnt = 0;
    bus.start = 1'b1; bus.mode = M_SHL; bus.amount = 4'd0; bus.sin = 1'b1;
    step();
    bus.start = 1'b0; bus.mode = M_HOLD; bus.sin = 1'b0;
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL zero_done got %b want 1", bus.done); end
    n_cmp++; if (bus.q !== 8'hF0) begin n_err++; $display("FAIL zero_q got %h want f0", bus.q); end
    for (int i = 0; i < 3; i++) begin
      busy_cnt += int'(bus.busy);
      step();
    end
    n_cmp++; if (busy_cnt !== 0) begin n_err++; $display("FAIL zero_busy got %0d want 0", busy_cnt); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL zero_done_after got %b want 0", bus.done); end
  endtask

  task automatic test_sync_clr();
    int done_cnt = 0, busy_cnt = 0;
    load(8'h01);
    bus.start = 1'b1; bus.mode = M_ROTL; bus.amount = 4'd6;
    step();
    bus.start = 1'b0; bus.mode = M_HOLD;
    step();
    bus.start = 1'b1; bus.mode = M_LOAD; bus.d = 8'hFF; bus.amount = 4'd2;
    step();
    bus.start = 1'b0; bus.mode = M_HOLD;
    n_cmp++; if (bus.q !== 8'h04) begin n_err++; $display("FAIL restart_ignored_q got %h want 04", bus.q); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL restart_busy got %b want 1", bus.busy); end
    bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    n_cmp++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL clr_q got %h want 00", bus.q); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL clr_busy got %b want 0", bus.busy); end
    for (int i = 0; i < 6; i++) begin
      done_cnt += int'(bus.done);
      busy_cnt += int'(bus.busy);
      step();
    end
    n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL clr_no_done got %0d want 0", done_cnt); end
    n_cmp++; if (busy_cnt !== 0) begin n_err++; $display("FAIL clr_stays_idle got %0d want 0", busy_cnt); end
    n_cmp++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL clr_q_after got %h want 00", bus.q); end
  endtask

  task automatic test_async_reset();
    load(8'h3C);
    bus.start = 1'b1; bus.mode = M_ROTR; bus.amount = 4'd5;
    step();
    bus.start = 1'b0; bus.mode = M_HOLD;
    step();
    n_cmp++; if (bus.q !== 8'h1E) begin n_err++; $display("FAIL pre_reset_q got %h want 1e", bus.q); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL async_q got %h want 00", bus.q); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL async_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL async_done got %b want 0", bus.done); end
    #1;
    reset = 1'b0;
    bus.en = 1'b1; bus.mode = M_LOAD; bus.d = 8'h5A;
    step();
    bus.en = 1'b0; bus.mode = M_HOLD;
    n_cmp++; if (bus.q !== 8'h5A) begin n_err++; $display("FAIL post_reset_load got %h want 5a", bus.q); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL post_reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_burst_rotl();
    test_burst_shr();
    test_single_ops();
    test_zero_amount();
    test_sync_clr();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
